ber_monitor: RTL and testbench
==============================

BER_MONITOR -- requirements
Module: ber_monitor

Interface
REQ-001 Parameter DATA_W, default 12, sets the word width of the TX and RX data paths.
REQ-002 Parameter DEPTH, default 8, sets the alignment FIFO depth in words (power of 2, >=2).
REQ-003 Parameter CNT_W, default 50, sets the bit-error counter width.
REQ-004 Parameter WIN_W, default 32, sets the width of the window-length and word counters.
REQ-005 CLK  input  1  is the single clock; all logic is on its rising edge.
REQ-006 reset  input  1  is a synchronous, active-high reset.
REQ-007 start  input  1  is a single-cycle pulse that begins (or restarts) a measurement window.
REQ-008 win_len  input  WIN_W  is the number of compared words per window; 0 means continuous; sampled on start.
REQ-009 tx_valid / tx_data  input  1 / DATA_W  carry a reference word to be pushed into the alignment FIFO.
REQ-010 rx_valid / rx_data  input  1 / DATA_W  carry a received word to be compared against the FIFO head.
REQ-011 Errors  output  CNT_W  is the accumulated bit-error count for the current or last window.
REQ-012 Words  output  WIN_W  is the number of words compared in the current or last window.
REQ-013 Error_flag  output  1  is a one-cycle pulse when a compared word has at least one bit error.
REQ-014 busy / done  output  1 / 1  indicate the RUN and DONE states respectively.
REQ-015 overrun / underrun  output  1 / 1  are sticky FIFO fault flags.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE->RUN on start; RUN->DONE when Words reaches the latched win_len (win_len != 0); DONE->RUN on start.
REQ-018 start in any state SHALL clear Errors, Words, overrun, underrun and the FIFO, latch win_len, and enter RUN on the next cycle.
REQ-019 In IDLE and DONE, tx_valid and rx_valid SHALL be ignored, and Errors and Words SHALL hold their values.
REQ-020 In RUN, tx_valid SHALL push tx_data into the FIFO; if the FIFO is full and there is no simultaneous pop, the word SHALL be dropped and overrun set.
REQ-021 In RUN, rx_valid with a non-empty FIFO SHALL pop the head and compare it with rx_data; a push and pop in the same cycle on a full FIFO are both accepted.
REQ-022 rx_valid with an empty FIFO SHALL discard rx_data and set underrun, even if a push occurs in the same cycle; Words SHALL not increment.
REQ-023 Each compare SHALL add popcount(head XOR rx_data), with width clog2(DATA_W+1), to Errors, and SHALL increment Words by 1.
REQ-024 Errors and Words SHALL update, and Error_flag SHALL pulse, on the first rising edge after the compare cycle (latency 1).
REQ-025 Errors SHALL saturate at all-ones; Words SHALL saturate at all-ones in continuous mode.
REQ-026 A compare that makes Words equal win_len SHALL be the last one counted; done SHALL assert in the same cycle that Words shows win_len.

Reset
REQ-027 reset SHALL force IDLE and empty the FIFO, and SHALL set Errors=0, Words=0, Error_flag=0, busy=0, done=0, overrun=0, underrun=0.
REQ-028 reset asserted mid-window SHALL abort the window with no partial result retained; reset has priority over start.

Configuration
REQ-029 With macro BER_MONITOR_THRESH_EN defined, the block SHALL add input thresh[CNT_W] (sampled on start) and a sticky output alarm, set when Errors > thresh and cleared by start or reset.
REQ-030 Without BER_MONITOR_THRESH_EN, the thresh and alarm ports SHALL not exist and the remaining behaviour SHALL be unchanged.

Verification
REQ-031 DATA_W=12, win_len=4, four matched TX/RX pairs of 12'h66A -> Errors=0, Words=4, done=1, Error_flag never pulses.
REQ-032 TX 12'hE6A, RX 12'h66A (1 bit), then TX 12'hEFA, RX 12'h000 (9 bits) -> Errors=10; Error_flag pulses twice, each one cycle after its rx_valid.
REQ-033 DEPTH=8: nine tx_valid with no rx_valid -> overrun=1 and FIFO holds the first 8 words; rx_valid on empty FIFO -> underrun=1, Words unchanged.
REQ-034 reset asserted after 2 of 4 compares -> all outputs 0 and state IDLE; a new start then produces a clean 4-word result.
REQ-035 CNT_W=4, continuous mode, 20 compares of 1 bit error each -> Errors saturates at 15 and busy stays 1.
REQ-036 With BER_MONITOR_THRESH_EN defined and thresh=2: 3 single-bit errors -> alarm=1 one cycle after the third compare; start clears it.

Source files
------------

// File: rtl/ber_monitor_if.sv
// ber_monitor_if
//   Groups the reference (TX) and received (RX) word streams that feed the
//   bit-error-rate monitor.
//   Signals:
//     tx_valid / tx_data : reference word to queue for alignment
//     rx_valid / rx_data : received word to compare against the oldest reference
//   Modports:
//     master : the side that produces both streams
//     slave  : the monitor that consumes them
interface ber_monitor_if #(
  parameter int DATA_W = 12
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;

  modport master (output tx_valid, tx_data, rx_valid, rx_data);
  modport slave  (input  tx_valid, tx_data, rx_valid, rx_data);
endinterface

// File: rtl/ber_monitor.sv
// ber_monitor
//   Measures bit errors between a reference word stream and a received word
//   stream. Reference words are queued in an alignment FIFO; each received
//   word pops the oldest reference and the popcount of their XOR is added to
//   an error counter. A window of win_len compared words (0 = continuous) is
//   started by a one-cycle start pulse.
//   Ports:
//     CLK, reset      : clock and synchronous active-high reset
//     start, win_len  : begin/restart a window, window length (0 = continuous)
//     bus (slave)     : tx_valid/tx_data and rx_valid/rx_data streams
//     Errors, Words   : accumulated bit errors and compared-word count
//     Error_flag      : one-cycle pulse for a compared word with any bit error
//     busy, done      : measurement running / window complete
//     overrun/underrun: sticky FIFO fault flags
//     thresh, alarm   : only with BER_MONITOR_THRESH_EN defined; alarm is a
//                       sticky flag set once Errors exceeds thresh
module ber_monitor #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 50,
  parameter int WIN_W  = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [WIN_W-1:0]  win_len,
  ber_monitor_if.slave      bus,
`ifdef BER_MONITOR_THRESH_EN
  input  logic [CNT_W-1:0]  thresh,
  output logic              alarm,
`endif
  output logic [CNT_W-1:0]  Errors,
  output logic [WIN_W-1:0]  Words,
  output logic              Error_flag,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              underrun
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PC_W  = $clog2(DATA_W + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  errors_q, errors_d;
  logic [WIN_W-1:0]  words_q, words_d;
  logic [WIN_W-1:0]  winLen_q, winLen_d;
  logic              flag_q, flag_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;
  logic [AW-1:0]     wrPtr_q, wrPtr_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              pushEn;
  logic              popEn;
  logic [DATA_W-1:0] diffBits;
  logic [PC_W-1:0]   diffCount;
  logic [SUM_W-1:0]  errSum;
  logic [WIN_W-1:0]  wordsInc;

`ifdef BER_MONITOR_THRESH_EN
  logic [CNT_W-1:0]  thresh_q, thresh_d;
  logic              alarm_q, alarm_d;
`endif

  // Bit-difference count between the FIFO head and the received word, plus
  // the saturating next values of both counters. Only used when a pop occurs.
  always_comb begin
    diffBits  = mem[rdPtr_q] ^ bus.rx_data;
    diffCount = '0;
    for (int i = 0; i < DATA_W; i++) begin
      diffCount = diffCount + PC_W'(diffBits[i]);
    end
    errSum   = SUM_W'(errors_q) + SUM_W'(diffCount);
    wordsInc = (words_q == '1) ? words_q : words_q + WIN_W'(1);
  end

  // Next-state and datapath control. start overrides everything in any state
  // and throws away whatever the streams present that cycle, because the
  // FIFO is being flushed. A word hitting a full FIFO still gets in when a
  // pop frees a slot the same cycle; a receive on an empty FIFO cannot use a
  // word pushed in that very cycle.
  always_comb begin
    state_d    = state_q;
    errors_d   = errors_q;
    words_d    = words_q;
    winLen_d   = winLen_q;
    flag_d     = 1'b0;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    pushEn     = 1'b0;
    popEn      = 1'b0;
`ifdef BER_MONITOR_THRESH_EN
    thresh_d   = thresh_q;
    alarm_d    = alarm_q;
`endif

    if (start) begin
      state_d    = RUN;
      errors_d   = '0;
      words_d    = '0;
      winLen_d   = win_len;
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      count_d    = '0;
`ifdef BER_MONITOR_THRESH_EN
      thresh_d   = thresh;
      alarm_d    = 1'b0;
`endif
    end else if (state_q == RUN) begin
      popEn  = bus.rx_valid && (count_q != '0);
      pushEn = bus.tx_valid && ((count_q != (AW+1)'(DEPTH)) || popEn);

      if (bus.rx_valid && (count_q == '0)) underrun_d = 1'b1;
      if (bus.tx_valid && !pushEn)         overrun_d  = 1'b1;

      if (pushEn) wrPtr_d = wrPtr_q + AW'(1);
      if (popEn)  rdPtr_d = rdPtr_q + AW'(1);
      case ({pushEn, popEn})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase

      if (popEn) begin
        errors_d = (errSum > SUM_W'(ERR_MAX)) ? ERR_MAX : errSum[CNT_W-1:0];
        words_d  = wordsInc;
        flag_d   = (diffCount != '0);
        if ((winLen_q != '0) && (wordsInc == winLen_q)) state_d = DONE;
      end

`ifdef BER_MONITOR_THRESH_EN
      if (errors_d > thresh_q) alarm_d = 1'b1;
`endif
    end
  end

  // State and counter registers; reset wins over start and discards any
  // partial window.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= IDLE;
      errors_q   <= '0;
      words_q    <= '0;
      winLen_q   <= '0;
      flag_q     <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
`ifdef BER_MONITOR_THRESH_EN
      thresh_q   <= '0;
      alarm_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      errors_q   <= errors_d;
      words_q    <= words_d;
      winLen_q   <= winLen_d;
      flag_q     <= flag_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
`ifdef BER_MONITOR_THRESH_EN
      thresh_q   <= thresh_d;
      alarm_q    <= alarm_d;
`endif
    end
  end

  // FIFO storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge CLK) begin
    if (pushEn && !reset) mem[wrPtr_q] <= bus.tx_data;
  end

  assign Errors     = errors_q;
  assign Words      = words_q;
  assign Error_flag = flag_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign overrun    = overrun_q;
  assign underrun   = underrun_q;
`ifdef BER_MONITOR_THRESH_EN
  assign alarm      = alarm_q;
`endif

endmodule

// File: tb/tb_ber_monitor.sv
// tb_ber_monitor
//   Directed bench for ber_monitor. Instance A uses the default widths and
//   is driven from a table of per-cycle vectors plus hand-written sequences
//   for reset abort and the threshold alarm; instance B uses a 4-bit error
//   counter to exercise saturation.
module tb_ber_monitor;

  localparam int DATA_W  = 12;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 50;
  localparam int WIN_W   = 32;
  localparam int CNT_W_B = 4;

  logic CLK = 1'b0;
  logic reset;

  logic              startA, startB;
  logic [WIN_W-1:0]  winLenA, winLenB;
  logic [CNT_W-1:0]  errorsA;
  logic [CNT_W_B-1:0] errorsB;
  logic [WIN_W-1:0]  wordsA, wordsB;
  logic flagA, busyA, doneA, overA, underA;
  logic flagB, busyB, doneB, overB, underB;
`ifdef BER_MONITOR_THRESH_EN
  logic [CNT_W-1:0]   threshA;
  logic [CNT_W_B-1:0] threshB;
  logic               alarmA, alarmB;
`endif

  int passCount  = 0;
  int checkCount = 0;

  ber_monitor_if #(.DATA_W(DATA_W)) busA ();
  ber_monitor_if #(.DATA_W(DATA_W)) busB ();

  ber_monitor #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dutA (
    .CLK(CLK), .reset(reset), .start(startA), .win_len(winLenA), .bus(busA),
`ifdef BER_MONITOR_THRESH_EN
    .thresh(threshA), .alarm(alarmA),
`endif
    .Errors(errorsA), .Words(wordsA), .Error_flag(flagA), .busy(busyA),
    .done(doneA), .overrun(overA), .underrun(underA)
  );

  ber_monitor #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W_B), .WIN_W(WIN_W)) dutB (
    .CLK(CLK), .reset(reset), .start(startB), .win_len(winLenB), .bus(busB),
`ifdef BER_MONITOR_THRESH_EN
    .thresh(threshB), .alarm(alarmB),
`endif
    .Errors(errorsB), .Words(wordsB), .Error_flag(flagB), .busy(busyB),
    .done(doneB), .overrun(overB), .underrun(underB)
  );

  // Free-running 10-time-unit clock.
  always #5 CLK = ~CLK;

  typedef struct {
    logic              start;
    logic [WIN_W-1:0]  winLen;
    logic              txValid;
    logic [DATA_W-1:0] txData;
    logic              rxValid;
    logic [DATA_W-1:0] rxData;
    logic [CNT_W-1:0]  expErrors;
    logic [WIN_W-1:0]  expWords;
    logic              expFlag;
    logic              expBusy;
    logic              expDone;
    logic              expOver;
    logic              expUnder;
  } vec_t;

  vec_t vecs[$];

  // Appends one cycle of stimulus with the outputs expected right after it.
  function automatic void addVec(input logic st, input int win,
                                 input logic txv, input int txd,
                                 input logic rxv, input int rxd,
                                 input longint eErr, input int eWords,
                                 input logic eFlag, input logic eBusy,
                                 input logic eDone, input logic eOver,
                                 input logic eUnder);
    vec_t v;
    v.start     = st;
    v.winLen    = WIN_W'(win);
    v.txValid   = txv;
    v.txData    = DATA_W'(txd);
    v.rxValid   = rxv;
    v.rxData    = DATA_W'(rxd);
    v.expErrors = CNT_W'(eErr);
    v.expWords  = WIN_W'(eWords);
    v.expFlag   = eFlag;
    v.expBusy   = eBusy;
    v.expDone   = eDone;
    v.expOver   = eOver;
    v.expUnder  = eUnder;
    vecs.push_back(v);
  endfunction

  // Compares one observed value with the bench's expectation.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Drives one cycle on instance A at the falling edge, then waits until just
  // after the next rising edge so outputs reflect that cycle.
  task automatic applyStimulus(input vec_t v);
    @(negedge CLK);
    startA        = v.start;
    winLenA       = v.winLen;
    busA.tx_valid = v.txValid;
    busA.tx_data  = v.txData;
    busA.rx_valid = v.rxValid;
    busA.rx_data  = v.rxData;
    @(posedge CLK);
    #1;
  endtask

  task automatic stepA(input logic st, input int win, input logic txv, input int txd,
                       input logic rxv, input int rxd);
    vec_t v;
    v = '{default: '0};
    v.start = st; v.winLen = WIN_W'(win);
    v.txValid = txv; v.txData = DATA_W'(txd);
    v.rxValid = rxv; v.rxData = DATA_W'(rxd);
    applyStimulus(v);
  endtask

  task automatic stepB(input logic st, input int win, input logic txv, input int txd,
                       input logic rxv, input int rxd);
    @(negedge CLK);
    startB = st; winLenB = WIN_W'(win);
    busB.tx_valid = txv; busB.tx_data = DATA_W'(txd);
    busB.rx_valid = rxv; busB.rx_data = DATA_W'(rxd);
    @(posedge CLK);
    #1;
  endtask

  task automatic checkRow(input string tag, input vec_t v);
    checkOutput({tag, ".Errors"},   64'(errorsA), 64'(v.expErrors));
    checkOutput({tag, ".Words"},    64'(wordsA),  64'(v.expWords));
    checkOutput({tag, ".flag"},     64'(flagA),   64'(v.expFlag));
    checkOutput({tag, ".busy"},     64'(busyA),   64'(v.expBusy));
    checkOutput({tag, ".done"},     64'(doneA),   64'(v.expDone));
    checkOutput({tag, ".overrun"},  64'(overA),   64'(v.expOver));
    checkOutput({tag, ".underrun"}, 64'(underA),  64'(v.expUnder));
  endtask

  initial begin
    vec_t allZero;
    allZero = '{default: '0};

    reset = 1'b1;
    startA = 1'b0; winLenA = '0; startB = 1'b0; winLenB = '0;
    busA.tx_valid = 1'b0; busA.tx_data = '0; busA.rx_valid = 1'b0; busA.rx_data = '0;
    busB.tx_valid = 1'b0; busB.tx_data = '0; busB.rx_valid = 1'b0; busB.rx_data = '0;
`ifdef BER_MONITOR_THRESH_EN
    threshA = '1; threshB = '1;
`endif
    repeat (2) @(posedge CLK);
    #1;
    checkRow("reset", allZero);
    @(negedge CLK);
    reset = 1'b0;

    // Window of four matched words, then DONE ignoring traffic.
    addVec(1, 4, 0, 0,      0, 0,      0, 0, 0, 1, 0, 0, 0);
    addVec(0, 0, 1, 'h66A,  0, 0,      0, 0, 0, 1, 0, 0, 0);
    addVec(0, 0, 1, 'h66A,  1, 'h66A,  0, 1, 0, 1, 0, 0, 0);
    addVec(0, 0, 1, 'h66A,  1, 'h66A,  0, 2, 0, 1, 0, 0, 0);
    addVec(0, 0, 1, 'h66A,  1, 'h66A,  0, 3, 0, 1, 0, 0, 0);
    addVec(0, 0, 0, 0,      1, 'h66A,  0, 4, 0, 0, 1, 0, 0);
    addVec(0, 0, 1, 'h123,  1, 'h000,  0, 4, 0, 0, 1, 0, 0);
    // One-bit then nine-bit error, continuous mode.
    addVec(1, 0, 0, 0,      0, 0,      0, 0, 0, 1, 0, 0, 0);
    addVec(0, 0, 1, 'hE6A,  0, 0,      0, 0, 0, 1, 0, 0, 0);
    addVec(0, 0, 1, 'hEFA,  1, 'h66A,  1, 1, 1, 1, 0, 0, 0);
    addVec(0, 0, 0, 0,      0, 0,      1, 1, 0, 1, 0, 0, 0);
    addVec(0, 0, 0, 0,      1, 'h000, 10, 2, 1, 1, 0, 0, 0);
    addVec(0, 0, 0, 0,      0, 0,     10, 2, 0, 1, 0, 0, 0);
    // Overrun on the ninth push; the first eight words are read back intact.
    addVec(1, 0, 0, 0,      0, 0,      0, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) addVec(0, 0, 1, i, 0, 0, 0, 0, 0, 1, 0, (i == 9), 0);
    for (int i = 1; i <= 8; i++) addVec(0, 0, 0, 0, 1, i, 0, i, 0, 1, 0, 1, 0);
    addVec(0, 0, 0, 0,      1, 'h0AB,  0, 8, 0, 1, 0, 1, 1);
    // start clears flags; push and pop together on a full FIFO both land.
    addVec(1, 0, 0, 0,      0, 0,      0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) addVec(0, 0, 1, 'h100 + i, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    addVec(0, 0, 1, 'h1FF,  1, 'h100,  0, 1, 0, 1, 0, 0, 0);
    for (int i = 1; i < 8; i++) addVec(0, 0, 0, 0, 1, 'h100 + i, 0, 1 + i, 0, 1, 0, 0, 0);
    addVec(0, 0, 0, 0,      1, 'h1FF,  0, 9, 0, 1, 0, 0, 0);
    // Receive on empty FIFO with a simultaneous push: underrun, push kept.
    addVec(1, 0, 0, 0,      0, 0,      0, 0, 0, 1, 0, 0, 0);
    addVec(0, 0, 1, 'h0F0,  1, 'h555,  0, 0, 0, 1, 0, 0, 1);
    addVec(0, 0, 0, 0,      1, 'h0F0,  0, 1, 0, 1, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkRow($sformatf("row%0d", i), vecs[i]);
    end

    // Reset in mid-window, asserted together with start, then a clean window.
    stepA(1, 4, 0, 0, 0, 0);
    repeat (4) stepA(0, 0, 1, 'hFFF, 0, 0);
    stepA(0, 0, 0, 0, 1, 'h000);
    stepA(0, 0, 0, 0, 1, 'h000);
    checkOutput("abort.pre.Errors", 64'(errorsA), 64'd24);
    checkOutput("abort.pre.Words",  64'(wordsA),  64'd2);
    @(negedge CLK);
    reset = 1'b1; startA = 1'b1; winLenA = WIN_W'(4);
    busA.rx_valid = 1'b0; busA.tx_valid = 1'b0;
    @(posedge CLK);
    #1;
    checkRow("abort", allZero);
    @(negedge CLK);
    reset = 1'b0; startA = 1'b0;
    stepA(0, 0, 0, 0, 1, 'h000);
    checkOutput("idle.busy",     64'(busyA),  64'd0);
    checkOutput("idle.underrun", 64'(underA), 64'd0);
    stepA(1, 4, 0, 0, 0, 0);
    stepA(0, 0, 1, 'h000, 0, 0);
    repeat (3) stepA(0, 0, 1, 'h000, 1, 'h000);
    stepA(0, 0, 0, 0, 1, 'h000);
    checkOutput("clean.Errors", 64'(errorsA), 64'd0);
    checkOutput("clean.Words",  64'(wordsA),  64'd4);
    checkOutput("clean.done",   64'(doneA),   64'd1);

    // Saturation of a 4-bit error counter in continuous mode.
    stepB(1, 0, 0, 0, 0, 0);
    stepB(0, 0, 1, 'h001, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      stepB(0, 0, (k < 20), 'h001, 1, 'h000);
      checkOutput($sformatf("sat%0d.Errors", k), 64'(errorsB), 64'((k > 15) ? 15 : k));
      checkOutput($sformatf("sat%0d.Words", k),  64'(wordsB),  64'(k));
      checkOutput($sformatf("sat%0d.busy", k),   64'(busyB),   64'd1);
    end

`ifdef BER_MONITOR_THRESH_EN
    // Alarm once errors exceed a threshold of 2; start clears it.
    threshA = CNT_W'(2);
    stepA(1, 0, 0, 0, 0, 0);
    stepA(0, 0, 1, 'h001, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      stepA(0, 0, (k < 3), 'h001, 1, 'h000);
      checkOutput($sformatf("alarm%0d", k), 64'(alarmA), 64'(k >= 3));
    end
    stepA(1, 0, 0, 0, 0, 0);
    checkOutput("alarm.clear", 64'(alarmA), 64'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
